// File: rtl/nested_sqrt_pipe_pkg.sv
// rtl/nested_sqrt_pipe_pkg.sv - shared latency and saturating-add helpers for nested_sqrt_pipe
package nested_sqrt_pkg;

    localparam int MAX_W = 64;

    function automatic int calc_lat(input int levels, input int isqrt_lat);
        return levels * (isqrt_lat + 1);
    endfunction

    function automatic logic [MAX_W:0] sat_limit(input int unsigned w);
        logic [MAX_W:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (one << w) - one;
    endfunction

    // Operands are zero-extended to MAX_W; the limit is 2^w-1 of the caller's width.
    function automatic logic sat_ovf(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                     input int unsigned w);
        logic [MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s > sat_limit(w);
    endfunction

    function automatic logic [MAX_W-1:0] sat_sum(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                                 input int unsigned w);
        logic [MAX_W:0] s;
        logic [MAX_W:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = sat_limit(w);
        return (s > lim) ? lim[MAX_W-1:0] : s[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/nested_sqrt_pipe_if.sv
// rtl/nested_sqrt_pipe_if.sv - argument and result bundle of nested_sqrt_pipe
interface nested_sqrt_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int LEVELS = 3,
    parameter int TAG_W  = 8
);
    logic                    arg_vld;
    logic [LEVELS*WIDTH-1:0] args;
    logic [TAG_W-1:0]        tag_in;
    logic                    res_vld;
    logic [WIDTH/2-1:0]      res;
    logic                    res_sat;
    logic [TAG_W-1:0]        tag_out;

    modport master (output arg_vld, args, tag_in, input res_vld, res, res_sat, tag_out);
    modport slave  (input arg_vld, args, tag_in, output res_vld, res, res_sat, tag_out);
endinterface

// File: rtl/nested_sqrt_pipe_isqrt.sv
// rtl/nested_sqrt_pipe_isqrt.sv - pipelined floor square root, one result bit per stage, WIDTH/2 stages
module isqrt #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_vld,
    input  logic [WIDTH-1:0]   x,
    output logic               y_vld,
    output logic [WIDTH/2-1:0] y
);
    localparam int N  = WIDTH / 2;
    localparam int RW = N + 3;

    logic [N-1:0]     vld_q, vld_d;
    logic [WIDTH-1:0] x_q [N], x_d [N], x_p [N+1];
    logic [RW-1:0]    rem_q [N], rem_d [N], rem_p [N+1];
    logic [N-1:0]     root_q [N], root_d [N], root_p [N+1];

    // Index 0 of the *_p arrays is the module input, index i+1 is stage i.
    always_comb begin
        logic [RW-1:0] cur;
        logic [RW-1:0] trial;
        vld_d     = N'({vld_q, x_vld});
        x_p[0]    = x;
        rem_p[0]  = '0;
        root_p[0] = '0;
        for (int i = 0; i < N; i++) begin
            x_p[i+1]    = x_q[i];
            rem_p[i+1]  = rem_q[i];
            root_p[i+1] = root_q[i];
        end
        for (int i = 0; i < N; i++) begin
            cur   = {rem_p[i][RW-3:0], x_p[i][WIDTH-1 -: 2]};
            trial = (RW'(root_p[i]) << 2) | RW'(1);
            x_d[i] = x_p[i] << 2;
            if (cur >= trial) begin
                rem_d[i]  = cur - trial;
                root_d[i] = {root_p[i][N-2:0], 1'b1};
            end else begin
                rem_d[i]  = cur;
                root_d[i] = {root_p[i][N-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) vld_q <= '0;
        else      vld_q <= vld_d;
        for (int i = 0; i < N; i++) begin
            if (vld_d[i]) begin
                x_q[i]    <= x_d[i];
                rem_q[i]  <= rem_d[i];
                root_q[i] <= root_d[i];
            end
        end
    end

    assign y_vld = vld_q[N-1];
    assign y     = root_p[N];
endmodule

// File: rtl/nested_sqrt_pipe_vdelay.sv
// rtl/nested_sqrt_pipe_vdelay.sv - valid-gated delay line; data stages load only with their valid
module nsq_vdelay #(
    parameter int DATA_W = 1,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);
    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out_vld        = in_vld;
        assign out_data       = in_data;
    end else begin : g_pipe
        logic [DEPTH-1:0]  vld_q, vld_d;
        logic [DATA_W-1:0] data_q [DEPTH];
        logic [DATA_W-1:0] data_d [DEPTH];

        always_comb begin
            vld_d     = DEPTH'({vld_q, in_vld});
            data_d[0] = in_data;
            for (int i = 1; i < DEPTH; i++) data_d[i] = data_q[i-1];
        end

        always_ff @(posedge clk) begin
            if (!rst) vld_q <= '0;
            else      vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_d[i]) data_q[i] <= data_d[i];
            end
        end

        assign out_vld  = vld_q[DEPTH-1];
        assign out_data = data_q[DEPTH-1];
    end
endmodule

// File: rtl/nested_sqrt_pipe.sv
// rtl/nested_sqrt_pipe.sv - fully pipelined nested isqrt evaluator with saturation flag, tag and occupancy
module nested_sqrt_pipe
    import nested_sqrt_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LEVELS    = 3,
    parameter int ISQRT_LAT = WIDTH / 2,
    parameter int TAG_W     = 8
) (
    input  logic clk,
    input  logic rst,
    nested_sqrt_pipe_if.slave bus,
    output logic [$clog2(calc_lat(LEVELS, ISQRT_LAT) + 1)-1:0] inflight,
    output logic idle
);
    localparam int L     = calc_lat(LEVELS, ISQRT_LAT);
    localparam int CNT_W = $clog2(L + 1);
    localparam int HW    = WIDTH / 2;

    logic [WIDTH-1:0]  x_dly [LEVELS];
    logic [HW-1:0]     sq_y  [LEVELS];
    logic [LEVELS-1:0] x_dly_vld, sq_vld, sat_dly_vld, sat_dly;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int J = LEVELS - 1 - k;

        logic [WIDTH-1:0] r_prev, s_d, s_q;
        logic             sat_prev, sat_d, sat_q, s_vld_d, s_vld_q;

        nsq_vdelay #(.DATA_W(WIDTH), .DEPTH(k * (ISQRT_LAT + 1))) u_x_dly (
            .clk(clk), .rst(rst),
            .in_vld(bus.arg_vld), .in_data(bus.args[J*WIDTH +: WIDTH]),
            .out_vld(x_dly_vld[k]), .out_data(x_dly[k])
        );

        // Operand, previous root and previous sat flag all arrive in the same cycle.
        if (k == 0) begin : g_first
            assign r_prev   = '0;
            assign sat_prev = 1'b0;
            assign s_vld_d  = x_dly_vld[k];
        end else begin : g_next
            assign r_prev   = WIDTH'(sq_y[k-1]);
            assign sat_prev = sat_dly[k-1];
            assign s_vld_d  = x_dly_vld[k] & sq_vld[k-1] & sat_dly_vld[k-1];
        end

        always_comb begin
            s_d   = WIDTH'(sat_sum(MAX_W'(x_dly[k]), MAX_W'(r_prev), WIDTH));
            sat_d = sat_prev | sat_ovf(MAX_W'(x_dly[k]), MAX_W'(r_prev), WIDTH);
        end

        always_ff @(posedge clk) begin
            if (!rst) s_vld_q <= 1'b0;
            else      s_vld_q <= s_vld_d;
            if (s_vld_d) begin
                s_q   <= s_d;
                sat_q <= sat_d;
            end
        end

        isqrt #(.WIDTH(WIDTH)) u_isqrt (
            .clk(clk), .rst(rst),
            .x_vld(s_vld_q), .x(s_q),
            .y_vld(sq_vld[k]), .y(sq_y[k])
        );

        nsq_vdelay #(.DATA_W(1), .DEPTH(ISQRT_LAT)) u_sat_dly (
            .clk(clk), .rst(rst),
            .in_vld(s_vld_q), .in_data(sat_q),
            .out_vld(sat_dly_vld[k]), .out_data(sat_dly[k])
        );
    end

    logic             tag_dly_vld;
    logic [TAG_W-1:0] tag_dly;

    nsq_vdelay #(.DATA_W(TAG_W), .DEPTH(L)) u_tag_dly (
        .clk(clk), .rst(rst),
        .in_vld(bus.arg_vld), .in_data(bus.tag_in),
        .out_vld(tag_dly_vld), .out_data(tag_dly)
    );

    logic             out_vld_d, out_vld_q, res_sat_d, res_sat_q;
    logic [HW-1:0]    res_d, res_q;
    logic [TAG_W-1:0] tag_d, tag_q;
    logic [CNT_W-1:0] inflight_d, inflight_q;

    // The counter decrements on the edge that raises res_vld, so it never exceeds L.
    always_comb begin
        out_vld_d = sq_vld[LEVELS-1] & sat_dly_vld[LEVELS-1] & tag_dly_vld;
        res_d     = sq_y[LEVELS-1];
        res_sat_d = sat_dly[LEVELS-1];
        tag_d     = tag_dly;
        case ({bus.arg_vld, out_vld_d})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld_q  <= 1'b0;
            res_q      <= '0;
            res_sat_q  <= 1'b0;
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            inflight_q <= inflight_d;
            if (out_vld_d) begin
                res_q     <= res_d;
                res_sat_q <= res_sat_d;
                tag_q     <= tag_d;
            end
        end
    end

    assign bus.res_vld = out_vld_q;
    assign bus.res     = res_q;
    assign bus.res_sat = res_sat_q;
    assign bus.tag_out = tag_q;
    assign inflight    = inflight_q;
    assign idle        = (inflight_q == '0);
endmodule

// File: tb/tb_nested_sqrt_pipe.sv
// tb/tb_nested_sqrt_pipe.sv - self-checking bench for nested_sqrt_pipe against an arithmetic reference
module tb_nested_sqrt_pipe;
    localparam int WIDTH     = 32;
    localparam int LEVELS    = 3;
    localparam int ISQRT_LAT = 16;
    localparam int TAG_W     = 8;
    localparam int L         = 51;
    localparam longint MAXV  = 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        logic [15:0] res;
        logic        sat;
        logic [7:0]  tag;
        int          due;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [5:0] inflight;
    logic       idle;

    nested_sqrt_pipe_if #(.WIDTH(WIDTH), .LEVELS(LEVELS), .TAG_W(TAG_W)) bus ();

    nested_sqrt_pipe #(.WIDTH(WIDTH), .LEVELS(LEVELS), .ISQRT_LAT(ISQRT_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .inflight(inflight), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          reset_seen = 0;
    int          peak    = 0;
    exp_t        q[$];
    logic [15:0] last_res = '0;
    logic        last_sat = 1'b0;
    logic [7:0]  last_tag = '0;
    logic [31:0] last_inner = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint ref_isqrt(input longint v);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    function automatic exp_t ref_model(input logic [95:0] a, input logic [7:0] tg);
        exp_t   e;
        longint acc = 0;
        longint s;
        bit     sat = 0;
        for (int k = 0; k < LEVELS; k++) begin
            int j = LEVELS - 1 - k;
            s = longint'(a[j*WIDTH +: WIDTH]) + acc;
            if (s > MAXV) begin
                s   = MAXV;
                sat = 1;
            end
            acc = ref_isqrt(s);
        end
        e.res = acc[15:0];
        e.sat = sat;
        e.tag = tg;
        e.due = 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom_range(0, 255);
            2:       return 32'hFFFF_FFFF - $urandom_range(0, 70000);
            default: return $urandom_range(0, 1 << 20);
        endcase
    endfunction

    task automatic set_rand(input logic vld);
        bus.arg_vld = vld;
        bus.args    = {rand_op(), rand_op(), rand_op()};
        bus.tag_in  = 8'($urandom_range(0, 255));
    endtask

    // One clock: update the model with what the edge sampled, then check every output.
    task automatic tick();
        bit          rst_edge;
        bit          acc;
        logic [95:0] a;
        logic [7:0]  tg;
        exp_t        e;
        bit          exp_vld;
        rst_edge = (rst == 1'b0);
        acc      = (rst == 1'b1) && (bus.arg_vld == 1'b1);
        a        = bus.args;
        tg       = bus.tag_in;
        @(posedge clk);
        cyc++;
        if (rst_edge) begin
            q.delete();
            last_res   = '0;
            last_sat   = 1'b0;
            last_tag   = '0;
            reset_seen = 1;
        end else if (acc) begin
            e     = ref_model(a, tg);
            e.due = cyc + L;
            q.push_back(e);
            last_inner = a[95:64];
        end
        #1;
        if (!reset_seen) return;
        exp_vld = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e        = q.pop_front();
            exp_vld  = 1;
            last_res = e.res;
            last_sat = e.sat;
            last_tag = e.tag;
        end
        chk("res_vld", bus.res_vld, exp_vld);
        chk("res", bus.res, last_res);
        chk("res_sat", bus.res_sat, last_sat);
        chk("tag_out", bus.tag_out, last_tag);
        chk("inflight", inflight, q.size());
        chk("idle", idle, q.size() == 0);
        if (int'(inflight) > peak) peak = int'(inflight);
    endtask

    task automatic run_one(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                           input logic [7:0] tg, input logic [15:0] exp_res, input logic exp_sat);
        bus.arg_vld = 1'b1;
        bus.args    = {x2, x1, x0};
        bus.tag_in  = tg;
        tick();
        bus.arg_vld = 1'b0;
        repeat (L) tick();
        chk("dir_vld", bus.res_vld, 1'b1);
        chk("dir_res", bus.res, exp_res);
        chk("dir_sat", bus.res_sat, exp_sat);
        chk("dir_tag", bus.tag_out, tg);
        repeat (3) tick();
    endtask

    initial begin
        int first_cyc;
        int resume_cyc;
        rst         = 1'b0;
        bus.arg_vld = 1'b0;
        bus.args    = '0;
        bus.tag_in  = '0;
        repeat (3) tick();
        chk("rst_res_vld", bus.res_vld, 1'b0);
        chk("rst_inflight", inflight, 0);
        chk("rst_idle", idle, 1'b1);
        rst = 1'b1;
        while (cyc < 9) tick();

        run_one(32'd9, 32'd12, 32'd16, 8'h5A, 16'd3, 1'b0);
        run_one(32'd100, 32'd0, 32'd0, 8'h11, 16'd10, 1'b0);
        run_one(32'd0, 32'd0, 32'd0, 8'h22, 16'd0, 1'b0);
        run_one(32'd0, 32'd0, 32'd16, 8'h33, 16'd1, 1'b0);
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h44, 16'd65535, 1'b1);
        run_one(32'd0, 32'd0, 32'hFFFF_FFFF, 8'h55, 16'd15, 1'b0);

        peak = 0;
        for (int i = 0; i < 200; i++) begin
            set_rand(1'b1);
            tick();
        end
        for (int i = 0; i < 200; i++) begin
            set_rand($urandom_range(0, 99) >= 40);
            tick();
        end
        bus.arg_vld = 1'b0;
        repeat (L + 2) tick();
        chk("inflight_peak", peak, L);

        for (int i = 0; i < 30; i++) begin
            set_rand(1'b1);
            tick();
        end
        rst = 1'b0;
        set_rand(1'b1);
        tick();
        chk("inflight_after_rst", inflight, 0);
        rst         = 1'b1;
        bus.arg_vld = 1'b0;
        tick();
        resume_cyc = cyc + 1;
        first_cyc  = 0;
        for (int i = 0; i < L + 5; i++) begin
            set_rand(1'b1);
            tick();
            if (first_cyc == 0 && bus.res_vld === 1'b1) first_cyc = cyc;
        end
        chk("first_after_rst", first_cyc, resume_cyc + L);
        bus.arg_vld = 1'b0;
        repeat (L + 2) tick();

        for (int i = 0; i < 100; i++) begin
            set_rand(1'b0);
            tick();
            chk("x_vld0", dut.g_lvl[0].s_vld_q, 1'b0);
            chk("x_vld1", dut.g_lvl[1].s_vld_q, 1'b0);
            chk("x_vld2", dut.g_lvl[2].s_vld_q, 1'b0);
            chk("s0_hold", dut.g_lvl[0].s_q, last_inner);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
